// File: rtl/lc3b_types_pkg.sv
// Shared LC-3b pipeline types: machine word, instruction packet and the
// occupancy states of a pipeline stage register.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  // Instruction packet carried alongside each in-flight instruction.
  typedef struct packed {
    logic [3:0]  opcode;
    logic [2:0]  dr;
    logic [2:0]  sr1;
    logic [2:0]  sr2;
    logic [2:0]  flags;
    logic [15:0] pc;
  } lc3b_ipacket;

  // Occupancy of a two-entry stage register (head + skid).
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } lc3b_stage_state_t;

  localparam int LC3B_STAGE_PKT_W  = $bits(lc3b_ipacket);
  localparam int LC3B_STAGE_DATA_W = 3 * $bits(lc3b_word);

endpackage

// File: rtl/pipe_stage_reg_entry.sv
// One {valid, pkt, data} storage slot of a pipeline stage register.
// clear wins over load; zero additionally wipes the stored contents.
module pipe_stage_entry
  import lc3b_types::*;
#(
  parameter int PKT_W  = LC3B_STAGE_PKT_W,
  parameter int DATA_W = LC3B_STAGE_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic              zero_i,
  input  logic [PKT_W-1:0]  pkt_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [PKT_W-1:0]  pkt_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q, valid_d;
  logic [PKT_W-1:0]  pkt_q, pkt_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Next slot contents: a clear invalidates (and optionally zeroes), a load captures the input.
  always_comb begin
    valid_d = valid_q;
    pkt_d   = pkt_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = 1'b0;
      if (zero_i) begin
        pkt_d  = '0;
        data_d = '0;
      end
    end else if (load_i) begin
      valid_d = 1'b1;
      pkt_d   = pkt_i;
      data_d  = data_i;
    end
  end

  // Slot register with synchronous reset to an all-zero, invalid entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      pkt_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      pkt_q   <= pkt_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign pkt_o   = pkt_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake and a 2-entry
// skid buffer (head H + skid S), so in_ready comes straight from a flop.
// Supports flush, external hold and optional zeroing of bubbles.
// Optional feature: define MEM_WB_STAGE_PERF_EN to add the saturating
// hold / backpressure performance counters and their output ports.
module pipe_stage_reg
  import lc3b_types::*;
#(
  parameter int PKT_W       = LC3B_STAGE_PKT_W,
  parameter int DATA_W      = LC3B_STAGE_DATA_W,
  parameter int ZERO_BUBBLE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              hold,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PKT_W-1:0]  in_pkt,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PKT_W-1:0]  out_pkt,
  output logic [DATA_W-1:0] out_data
`ifdef MEM_WB_STAGE_PERF_EN
  ,
  output logic [31:0]       perf_hold_cnt,
  output logic [31:0]       perf_bp_cnt
`endif
);

  localparam logic ZeroBubble = (ZERO_BUBBLE != 0);

  logic              headValid, skidValid;
  logic [PKT_W-1:0]  headPkt, skidPkt, headPktIn;
  logic [DATA_W-1:0] headData, skidData, headDataIn;
  logic              headLoad, headClear, headFromSkid;
  logic              skidLoad, skidClear;
  logic              entryZero;
  logic              acc, deq;
  lc3b_stage_state_t state;

  assign in_ready  = ~skidValid;
  assign out_valid = headValid & ~hold;
  assign acc       = in_valid & in_ready;
  assign deq       = out_valid & out_ready;
  assign entryZero = flush & ZeroBubble;

  // Occupancy is fully determined by the two valid flops; S is only ever filled while H is valid.
  always_comb begin
    state = ST_EMPTY;
    if (skidValid)      state = ST_FULL;
    else if (headValid) state = ST_ONE;
  end

  // Slot control: flush empties both slots, otherwise advance according to accept/dequeue.
  always_comb begin
    headLoad     = 1'b0;
    headClear    = 1'b0;
    headFromSkid = 1'b0;
    skidLoad     = 1'b0;
    skidClear    = 1'b0;
    if (flush) begin
      headClear = 1'b1;
      skidClear = 1'b1;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (acc) headLoad = 1'b1;
        end
        ST_ONE: begin
          if (acc && deq)       headLoad  = 1'b1;
          else if (acc)         skidLoad  = 1'b1;
          else if (deq)         headClear = 1'b1;
        end
        ST_FULL: begin
          if (deq) begin
            headLoad     = 1'b1;
            headFromSkid = 1'b1;
            skidClear    = 1'b1;
          end
        end
        default: begin
          headClear = 1'b1;
          skidClear = 1'b1;
        end
      endcase
    end
  end

  assign headPktIn  = headFromSkid ? skidPkt  : in_pkt;
  assign headDataIn = headFromSkid ? skidData : in_data;

  pipe_stage_entry #(.PKT_W(PKT_W), .DATA_W(DATA_W)) uHead (
    .clk     (clk),
    .reset   (reset),
    .load_i  (headLoad),
    .clear_i (headClear),
    .zero_i  (entryZero),
    .pkt_i   (headPktIn),
    .data_i  (headDataIn),
    .valid_o (headValid),
    .pkt_o   (headPkt),
    .data_o  (headData)
  );

  pipe_stage_entry #(.PKT_W(PKT_W), .DATA_W(DATA_W)) uSkid (
    .clk     (clk),
    .reset   (reset),
    .load_i  (skidLoad),
    .clear_i (skidClear),
    .zero_i  (entryZero),
    .pkt_i   (in_pkt),
    .data_i  (in_data),
    .valid_o (skidValid),
    .pkt_o   (skidPkt),
    .data_o  (skidData)
  );

  // Bubbles show up as an all-zero NOP packet when zeroing is enabled, else the stale head is visible.
  always_comb begin
    out_pkt  = headPkt;
    out_data = headData;
    if (ZeroBubble && !out_valid) begin
      out_pkt  = '0;
      out_data = '0;
    end
  end

`ifdef MEM_WB_STAGE_PERF_EN
  logic [31:0] perfHoldCnt_q, perfHoldCnt_d;
  logic [31:0] perfBpCnt_q, perfBpCnt_d;

  // Saturating event counts; flush deliberately leaves them alone.
  always_comb begin
    perfHoldCnt_d = perfHoldCnt_q;
    perfBpCnt_d   = perfBpCnt_q;
    if (hold && headValid && (perfHoldCnt_q != 32'hFFFF_FFFF))
      perfHoldCnt_d = perfHoldCnt_q + 32'd1;
    if (out_valid && !out_ready && (perfBpCnt_q != 32'hFFFF_FFFF))
      perfBpCnt_d = perfBpCnt_q + 32'd1;
  end

  // Counter registers, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      perfHoldCnt_q <= '0;
      perfBpCnt_q   <= '0;
    end else begin
      perfHoldCnt_q <= perfHoldCnt_d;
      perfBpCnt_q   <= perfBpCnt_d;
    end
  end

  assign perf_hold_cnt = perfHoldCnt_q;
  assign perf_bp_cnt   = perfBpCnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed testbench for pipe_stage_reg: a ZERO_BUBBLE=1 instance (dut)
// and a ZERO_BUBBLE=0 instance (dut0) share all inputs.
// Counter checks are built when MEM_WB_STAGE_PERF_EN is defined.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        reset, flush, hold, inValid, outReady;
  logic [31:0] inPkt;
  logic [47:0] inData;
  logic        inReady, outValid, inReady0, outValid0;
  logic [31:0] outPkt, outPkt0;
  logic [47:0] outData, outData0;
  int          errors = 0;
  int          checks = 0;
`ifdef MEM_WB_STAGE_PERF_EN
  logic [31:0] perfHold, perfBp, perfHold0, perfBp0;
`endif

  always #5 clk = ~clk;

  pipe_stage_reg #(.PKT_W(32), .DATA_W(48), .ZERO_BUBBLE(1)) dut (
    .clk(clk), .reset(reset), .flush(flush), .hold(hold),
    .in_valid(inValid), .in_ready(inReady), .in_pkt(inPkt), .in_data(inData),
    .out_valid(outValid), .out_ready(outReady), .out_pkt(outPkt), .out_data(outData)
`ifdef MEM_WB_STAGE_PERF_EN
    , .perf_hold_cnt(perfHold), .perf_bp_cnt(perfBp)
`endif
  );

  pipe_stage_reg #(.PKT_W(32), .DATA_W(48), .ZERO_BUBBLE(0)) dut0 (
    .clk(clk), .reset(reset), .flush(flush), .hold(hold),
    .in_valid(inValid), .in_ready(inReady0), .in_pkt(inPkt), .in_data(inData),
    .out_valid(outValid0), .out_ready(outReady), .out_pkt(outPkt0), .out_data(outData0)
`ifdef MEM_WB_STAGE_PERF_EN
    , .perf_hold_cnt(perfHold0), .perf_bp_cnt(perfBp0)
`endif
  );

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    reset = 1'b1; flush = 1'b0; hold = 1'b0; inValid = 1'b0; outReady = 1'b0;
    inPkt = '0; inData = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    applyReset();
    checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %0b want 0", outValid); end
    checks++; if (inReady !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %0b want 1", inReady); end
    checks++; if (outPkt !== 32'h0) begin errors++; $display("[TB] FAIL reset_out_pkt got %h want 0", outPkt); end
    checks++; if (outData !== 48'h0) begin errors++; $display("[TB] FAIL reset_out_data got %h want 0", outData); end
`ifdef MEM_WB_STAGE_PERF_EN
    checks++; if (perfHold !== 32'd0 || perfBp !== 32'd0) begin errors++; $display("[TB] FAIL reset_perf got %0d/%0d want 0/0", perfHold, perfBp); end
`endif
  endtask

  task automatic test_throughput();
    inValid = 1'b1; inPkt = 32'h11; inData = 48'h1234; outReady = 1'b1;
    tick();
    checks++; if (outValid !== 1'b1 || outPkt !== 32'h11 || outData !== 48'h1234) begin
      errors++; $display("[TB] FAIL first_accept got v=%0b pkt=%h data=%h want v=1 pkt=11 data=1234", outValid, outPkt, outData);
    end
    for (int i = 0; i < 16; i++) begin
      inPkt = 32'h20 + i; inData = 48'h1000 + i;
      tick();
      checks++; if (outValid !== 1'b1 || outPkt !== 32'h20 + i || outData !== 48'h1000 + i || inReady !== 1'b1) begin
        errors++; $display("[TB] FAIL burst_%0d got v=%0b pkt=%h data=%h rdy=%0b want v=1 pkt=%h data=%h rdy=1",
                           i, outValid, outPkt, outData, inReady, 32'h20 + i, 48'h1000 + i);
      end
    end
    inValid = 1'b0;
    tick();
    checks++; if (outValid !== 1'b0 || outPkt !== 32'h0) begin
      errors++; $display("[TB] FAIL burst_drain got v=%0b pkt=%h want v=0 pkt=0", outValid, outPkt);
    end
  endtask

  task automatic test_backpressure();
    outReady = 1'b0; inValid = 1'b1; inPkt = 32'h1; inData = 48'hA1;
    tick();
    inPkt = 32'h2; inData = 48'hA2;
    tick();
    checks++; if (inReady !== 1'b0 || outValid !== 1'b1 || outPkt !== 32'h1) begin
      errors++; $display("[TB] FAIL bp_full got rdy=%0b v=%0b pkt=%h want rdy=0 v=1 pkt=1", inReady, outValid, outPkt);
    end
    inPkt = 32'h3; inData = 48'hA3;
    tick();
    checks++; if (inReady !== 1'b0 || outPkt !== 32'h1) begin
      errors++; $display("[TB] FAIL bp_stall got rdy=%0b pkt=%h want rdy=0 pkt=1", inReady, outPkt);
    end
    outReady = 1'b1;
    #1;
    checks++; if (outValid !== 1'b1 || outPkt !== 32'h1 || outData !== 48'hA1) begin
      errors++; $display("[TB] FAIL bp_out_A got v=%0b pkt=%h data=%h want v=1 pkt=1 data=a1", outValid, outPkt, outData);
    end
    tick();
    checks++; if (outValid !== 1'b1 || outPkt !== 32'h2 || outData !== 48'hA2 || inReady !== 1'b1) begin
      errors++; $display("[TB] FAIL bp_out_B got v=%0b pkt=%h data=%h rdy=%0b want v=1 pkt=2 data=a2 rdy=1", outValid, outPkt, outData, inReady);
    end
    tick();
    checks++; if (outValid !== 1'b1 || outPkt !== 32'h3 || outData !== 48'hA3) begin
      errors++; $display("[TB] FAIL bp_out_C got v=%0b pkt=%h data=%h want v=1 pkt=3 data=a3", outValid, outPkt, outData);
    end
    inValid = 1'b0;
    tick();
    checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL bp_no_dup got v=%0b want 0", outValid); end
  endtask

  task automatic test_flush();
    outReady = 1'b0; inValid = 1'b1; inPkt = 32'h1; inData = 48'hB1;
    tick();
    inPkt = 32'h2; inData = 48'hB2;
    tick();
    inPkt = 32'hD; inData = 48'hDD; flush = 1'b1;
    tick();
    flush = 1'b0; inValid = 1'b0;
    #1;
    checks++; if (outValid !== 1'b0 || inReady !== 1'b1) begin
      errors++; $display("[TB] FAIL flush_empty got v=%0b rdy=%0b want v=0 rdy=1", outValid, inReady);
    end
    checks++; if (outPkt !== 32'h0 || outData !== 48'h0) begin
      errors++; $display("[TB] FAIL flush_zero got pkt=%h data=%h want 0/0", outPkt, outData);
    end
    checks++; if (outValid0 !== 1'b0 || inReady0 !== 1'b1) begin
      errors++; $display("[TB] FAIL flush_empty_zb0 got v=%0b rdy=%0b want v=0 rdy=1", outValid0, inReady0);
    end
    outReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL flush_no_D_%0d got v=%0b pkt=%h want v=0", i, outValid, outPkt); end
    end
  endtask

  task automatic test_hold();
    outReady = 1'b1; inValid = 1'b1; inPkt = 32'h5; inData = 48'h55;
    tick();
    inValid = 1'b0; hold = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (outValid !== 1'b0 || outPkt !== 32'h0 || outData !== 48'h0) begin
        errors++; $display("[TB] FAIL hold_bubble_%0d got v=%0b pkt=%h data=%h want 0/0/0", i, outValid, outPkt, outData);
      end
      checks++; if (outValid0 !== 1'b0 || outPkt0 !== 32'h5) begin
        errors++; $display("[TB] FAIL hold_zb0_%0d got v=%0b pkt=%h want v=0 pkt=5", i, outValid0, outPkt0);
      end
      if (i < 2) tick();
    end
    tick();
    hold = 1'b0;
    #1;
    checks++; if (outValid !== 1'b1 || outPkt !== 32'h5 || outData !== 48'h55) begin
      errors++; $display("[TB] FAIL hold_release got v=%0b pkt=%h data=%h want v=1 pkt=5 data=55", outValid, outPkt, outData);
    end
    tick();
    checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL hold_single got v=%0b want 0", outValid); end
  endtask

  task automatic test_reset_midstream();
    outReady = 1'b0; inValid = 1'b1; inPkt = 32'h1; inData = 48'hC1;
    tick();
    inPkt = 32'h2; inData = 48'hC2;
    tick();
    reset = 1'b1; inPkt = 32'hE; inData = 48'hEE;
    tick();
    checks++; if (outValid !== 1'b0 || inReady !== 1'b1) begin
      errors++; $display("[TB] FAIL midreset got v=%0b rdy=%0b want v=0 rdy=1", outValid, inReady);
    end
    reset = 1'b0; inValid = 1'b0; outReady = 1'b1;
    tick();
    checks++; if (outValid !== 1'b0 || outPkt !== 32'h0) begin
      errors++; $display("[TB] FAIL midreset_no_E got v=%0b pkt=%h want v=0 pkt=0", outValid, outPkt);
    end
  endtask

`ifdef MEM_WB_STAGE_PERF_EN
  task automatic test_perf();
    applyReset();
    outReady = 1'b1; inValid = 1'b1; inPkt = 32'h7; inData = 48'h77;
    tick();
    inValid = 1'b0; hold = 1'b1;
    repeat (5) tick();
    hold = 1'b0; outReady = 1'b0;
    repeat (7) tick();
    checks++; if (perfHold !== 32'd5) begin errors++; $display("[TB] FAIL perf_hold got %0d want 5", perfHold); end
    checks++; if (perfBp !== 32'd7) begin errors++; $display("[TB] FAIL perf_bp got %0d want 7", perfBp); end
    outReady = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    checks++; if (perfHold !== 32'd5 || perfBp !== 32'd7) begin
      errors++; $display("[TB] FAIL perf_flush got %0d/%0d want 5/7", perfHold, perfBp);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_throughput();
    test_backpressure();
    test_flush();
    test_hold();
    test_reset_midstream();
`ifdef MEM_WB_STAGE_PERF_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
